// File: rtl/serial_mod_checker.sv
// Streaming divisibility checker: tracks a serial bit stream's value modulo a
// constant DIVISOR, in either MSB-first or LSB-first order.
module serial_mod_checker #(
  parameter int unsigned DIVISOR = 3,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned REM_W   = $clog2(DIVISOR)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             lsb_first,
  input  logic             din_valid,
  input  logic             din,
  output logic             dout,
  output logic [REM_W-1:0] rem,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             empty
);

  localparam logic [REM_W:0]   DIV_W   = (REM_W+1)'(DIVISOR);
  localparam logic [REM_W-1:0] POW_ONE = REM_W'(1);

  logic [REM_W-1:0] rem_q, pow_q;
  logic             mode_q, empty_q;
  logic [CNT_W-1:0] cnt_q;

  logic             init;
  logic [REM_W-1:0] base_rem, base_pow;
  logic             base_mode;
  logic [CNT_W-1:0] base_cnt;
  logic [REM_W:0]   t_msb, s_lsb, p_lsb;
  logic [REM_W-1:0] rem_nxt, pow_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  // A clear coinciding with a valid bit processes that bit against freshly
  // initialised state, so the datapath always starts from these "base" values.
  always_comb begin
    init      = reset || clear;
    base_rem  = init ? '0        : rem_q;
    base_pow  = init ? POW_ONE   : pow_q;
    base_mode = init ? lsb_first : mode_q;
    base_cnt  = init ? '0        : cnt_q;

    t_msb = {base_rem, din};
    s_lsb = {1'b0, base_rem} + (din ? {1'b0, base_pow} : '0);
    p_lsb = {base_pow, 1'b0};

    rem_nxt = '0;
    pow_nxt = base_pow;
    if (base_mode) begin
      rem_nxt = (s_lsb >= DIV_W) ? REM_W'(s_lsb - DIV_W) : s_lsb[REM_W-1:0];
      pow_nxt = (p_lsb >= DIV_W) ? REM_W'(p_lsb - DIV_W) : p_lsb[REM_W-1:0];
    end else begin
      rem_nxt = (t_msb >= DIV_W) ? REM_W'(t_msb - DIV_W) : t_msb[REM_W-1:0];
    end

    cnt_nxt = (&base_cnt) ? base_cnt : base_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset || (clear && !din_valid)) begin
      rem_q   <= '0;
      pow_q   <= POW_ONE;
      mode_q  <= lsb_first;
      empty_q <= 1'b1;
      cnt_q   <= '0;
    end else if (din_valid) begin
      rem_q   <= rem_nxt;
      pow_q   <= pow_nxt;
      mode_q  <= base_mode;
      empty_q <= 1'b0;
      cnt_q   <= cnt_nxt;
    end
  end

  assign dout    = !empty_q && (rem_q == '0);
  assign rem     = rem_q;
  assign bit_cnt = cnt_q;
  assign empty   = empty_q;

endmodule

// File: tb/tb_serial_mod_checker.sv
// Directed bench for serial_mod_checker across several divisors sharing one
// stimulus bus; each scenario checks only the instance it targets.
module tb_serial_mod_checker;

  logic clk = 1'b0;
  logic reset, clear, lsb_first, din_valid, din;

  logic       dout3, empty3;  logic [1:0] rem3;   logic [7:0] cnt3;
  logic       dout5, empty5;  logic [2:0] rem5;   logic [7:0] cnt5;
  logic       dout7, empty7;  logic [2:0] rem7;   logic [7:0] cnt7;
  logic       dout2, empty2;  logic [0:0] rem2;   logic [7:0] cnt2;
  logic       dout255, empty255; logic [7:0] rem255; logic [7:0] cnt255;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  serial_mod_checker #(.DIVISOR(3)) u3 (
    .clk(clk), .reset(reset), .clear(clear), .lsb_first(lsb_first),
    .din_valid(din_valid), .din(din),
    .dout(dout3), .rem(rem3), .bit_cnt(cnt3), .empty(empty3));
  serial_mod_checker #(.DIVISOR(5)) u5 (
    .clk(clk), .reset(reset), .clear(clear), .lsb_first(lsb_first),
    .din_valid(din_valid), .din(din),
    .dout(dout5), .rem(rem5), .bit_cnt(cnt5), .empty(empty5));
  serial_mod_checker #(.DIVISOR(7)) u7 (
    .clk(clk), .reset(reset), .clear(clear), .lsb_first(lsb_first),
    .din_valid(din_valid), .din(din),
    .dout(dout7), .rem(rem7), .bit_cnt(cnt7), .empty(empty7));
  serial_mod_checker #(.DIVISOR(2)) u2 (
    .clk(clk), .reset(reset), .clear(clear), .lsb_first(lsb_first),
    .din_valid(din_valid), .din(din),
    .dout(dout2), .rem(rem2), .bit_cnt(cnt2), .empty(empty2));
  serial_mod_checker #(.DIVISOR(255)) u255 (
    .clk(clk), .reset(reset), .clear(clear), .lsb_first(lsb_first),
    .din_valid(din_valid), .din(din),
    .dout(dout255), .rem(rem255), .bit_cnt(cnt255), .empty(empty255));

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic c, input logic l,
                      input logic v, input logic d);
    reset = r; clear = c; lsb_first = l; din_valid = v; din = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned m_rem, m_cnt, acc;
    logic        m_empty, b, v;
    int unsigned exp_rem3[3]  = '{1, 0, 0};
    int unsigned exp_rem5[3]  = '{1, 1, 0};
    int unsigned exp_pow5[3]  = '{2, 4, 3};
    logic        bits5[3]     = '{1'b1, 1'b0, 1'b1};
    logic        bits3[3]     = '{1'b1, 1'b1, 1'b0};
    logic        bits2[3]     = '{1'b1, 1'b0, 1'b1};

    reset = 1'b1; clear = 1'b0; lsb_first = 1'b0; din_valid = 1'b0; din = 1'b0;

    // D=3 MSB: reset with a valid 0 on din must not count it
    step(1, 0, 0, 1, 0);
    check("d3_rst_dout", dout3, 0);
    check("d3_rst_empty", empty3, 1);
    check("d3_rst_cnt", cnt3, 0);
    check("d3_rst_rem", rem3, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, bits3[i]);
      check("d3_msb_rem", rem3, exp_rem3[i]);
      check("d3_msb_dout", dout3, (i == 0) ? 0 : 1);
      check("d3_msb_cnt", cnt3, i + 1);
    end

    // D=5 LSB: values 1,1,5
    step(1, 0, 1, 0, 0);
    check("d5_rst_pow", u5.pow_q, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 1, bits5[i]);
      check("d5_lsb_rem", rem5, exp_rem5[i]);
      check("d5_lsb_dout", dout5, (i == 2) ? 1 : 0);
      check("d5_lsb_pow", u5.pow_q, exp_pow5[i]);
    end

    // D=7 MSB: random bits with gaps against a modulo reference model
    step(1, 0, 0, 0, 0);
    m_rem = 0; m_cnt = 0; m_empty = 1; acc = 0;
    for (int i = 0; i < 2000 && acc < 300; i++) begin
      v = ($urandom_range(0, 3) != 0);
      b = 1'($urandom_range(0, 1));
      step(0, 0, 0, v, b);
      if (v) begin
        acc++;
        m_rem = (2 * m_rem + b) % 7;
        m_empty = 0;
        if (m_cnt < 255) m_cnt++;
      end
      check("d7_rand_rem", rem7, m_rem);
      check("d7_rand_dout", dout7, (!m_empty && m_rem == 0) ? 1 : 0);
      check("d7_rand_cnt", cnt7, m_cnt);
    end
    check("d7_accepts", acc, 300);
    check("d7_cnt_sat", cnt7, 255);

    // D=3: clear with a valid bit starts a new LSB-first number with that bit
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    check("d3_pre_clear_rem", rem3, 2);
    step(0, 1, 1, 1, 1);
    check("d3_clrv_rem", rem3, 1);
    check("d3_clrv_cnt", cnt3, 1);
    check("d3_clrv_empty", empty3, 0);
    check("d3_clrv_mode", u3.mode_q, 1);
    step(0, 0, 0, 1, 1);
    check("d3_lsb_dout", dout3, 1);
    check("d3_lsb_rem", rem3, 0);
    step(0, 1, 0, 0, 1);
    check("d3_clr_empty", empty3, 1);
    check("d3_clr_cnt", cnt3, 0);
    check("d3_clr_dout", dout3, 0);
    step(0, 0, 1, 0, 1);
    check("d3_gap_cnt", cnt3, 0);

    // D=2 MSB: values 1,2,5 then reset mid-stream with valid high
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, bits2[i]);
      check("d2_dout", dout2, (i == 1) ? 1 : 0);
    end
    step(1, 0, 0, 1, 1);
    check("d2_rst_rem", rem2, 0);
    check("d2_rst_empty", empty2, 1);
    check("d2_rst_dout", dout2, 0);
    check("d2_rst_cnt", cnt2, 0);

    // D=255 MSB: sixteen ones, value 2^k-1 after k bits
    step(1, 0, 0, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      longint unsigned val;
      step(0, 0, 0, 1, 1);
      val = (64'd1 << k) - 1;
      check("d255_rem", rem255, int'(val % 255));
      check("d255_dout", dout255, (k == 8 || k == 16) ? 1 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
